ex_stage: RTL and testbench

Execute stage of the 5-stage RV32IM pipeline, between the ID/EX register and the MEM stage. Resolves operand forwarding from EX/MEM and MEM/WB and computes the RV32I ALU result plus single-cycle multiply. An iterative radix-2 divider covers DIV/DIVU/REM/REMU, and the stage raises a stall request while it runs. Owns the EX/MEM pipeline register that feeds the MEM stage.

---
 rtl/rv32_pkg.sv | 48 ++++
 rtl/div_unit.sv | 113 +++++++++++
 rtl/ex_stage.sv | 135 +++++++++++++
 tb/tb_ex_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32IM execute stage.
package rv32_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int          DIV_ITER    = 32;
  localparam logic [31:0] DIV_BY_ZERO = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] alu_out;
    logic [31:0] data_b;
    logic [4:0]  rd;
  } ex_mem_t;

  function automatic logic is_div_op(alu_op_e op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider: 1 issue cycle, 32 RUN cycles, 1 DONE cycle.
module div_unit
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic        rem_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_RUN     = RUN;
  localparam logic [1:0] S_DONE    = DONE;
  localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        rem_op_q, rem_op_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_shift;
  logic        fits;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    rem_op_d = rem_op_q;

    a_neg     = signed_op & a[31];
    b_neg     = signed_op & b[31];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    rem_shift = {rem_q, quot_q[31]};
    fits      = rem_shift >= {1'b0, dvsr_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          quot_d   = a_mag;
          rem_d    = '0;
          dvsr_d   = b_mag;
          q_neg_d  = (a_neg ^ b_neg) && (b != '0);
          r_neg_d  = a_neg;
          rem_op_d = rem_op;
        end
      end
      S_RUN: begin
        // Dividend bits shift out of quot_q while quotient bits shift in.
        quot_d = {quot_q[30:0], fits};
        rem_d  = fits ? 32'(rem_shift - {1'b0, dvsr_q}) : rem_shift[31:0];
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // 0x80000000 / -1 needs no override: the magnitude quotient 0x80000000
  // negates to itself and the remainder is already 0.
  always_comb begin
    if (rem_op_q)             result = r_neg_q ? -rem_q : rem_q;
    else if (dvsr_q == '0)    result = DIV_BY_ZERO;
    else                      result = q_neg_q ? -quot_q : quot_q;
  end

  assign busy = ((state_q == S_IDLE) && start) || (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      rem_op_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      rem_op_q <= rem_op_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: forwarding, ALU, single-cycle multiplier, iterative
// divider and the EX/MEM pipeline register.
module ex_stage
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ID_EX_reg_write,
  input  logic        ID_EX_mem_to_reg,
  input  logic        ID_EX_mem_read,
  input  logic        ID_EX_mem_write,
  input  logic [4:0]  ID_EX_alu_op,
  input  logic        ID_EX_alu_src,
  input  logic [31:0] ID_EX_dataA,
  input  logic [31:0] ID_EX_dataB,
  input  logic [31:0] ID_EX_imm,
  input  logic [4:0]  ID_EX_rs1,
  input  logic [4:0]  ID_EX_rs2,
  input  logic [4:0]  ID_EX_rd,
  input  logic        MEM_WB_reg_write,
  input  logic [4:0]  MEM_WB_rd,
  input  logic [31:0] wb_data,
  output logic        EX_MEM_reg_write,
  output logic        EX_MEM_mem_to_reg,
  output logic        EX_MEM_mem_read,
  output logic        EX_MEM_mem_write,
  output logic [31:0] EX_MEM_alu_out,
  output logic [31:0] EX_MEM_dataB,
  output logic [4:0]  EX_MEM_rd,
  output logic        ex_busy
);

  alu_op_e     op;
  ex_mem_t     ex_mem_q, ex_mem_d;
  logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res;
  logic [63:0] mul_a, mul_b, product;
  logic        div_start, div_busy, div_done;
  logic [31:0] div_result;

  assign op = alu_op_e'(ID_EX_alu_op);

  always_comb begin
    if (ex_mem_q.reg_write && ex_mem_q.rd != '0 && ex_mem_q.rd == ID_EX_rs1)
      fwd_a = ex_mem_q.alu_out;
    else if (MEM_WB_reg_write && MEM_WB_rd != '0 && MEM_WB_rd == ID_EX_rs1)
      fwd_a = wb_data;
    else
      fwd_a = ID_EX_dataA;

    if (ex_mem_q.reg_write && ex_mem_q.rd != '0 && ex_mem_q.rd == ID_EX_rs2)
      fwd_b = ex_mem_q.alu_out;
    else if (MEM_WB_reg_write && MEM_WB_rd != '0 && MEM_WB_rd == ID_EX_rs2)
      fwd_b = wb_data;
    else
      fwd_b = ID_EX_dataB;
  end

  assign op_a = fwd_a;
  assign op_b = ID_EX_alu_src ? ID_EX_imm : fwd_b;

  // 64-bit extension per operand signedness; the low 64 product bits are exact.
  assign mul_a   = (op == ALU_MULH || op == ALU_MULHSU) ? {{32{op_a[31]}}, op_a} : {32'b0, op_a};
  assign mul_b   = (op == ALU_MULH) ? {{32{op_b[31]}}, op_b} : {32'b0, op_b};
  assign product = mul_a * mul_b;

  // Reset also masks a pending issue so ex_busy is 0 for as long as reset is held.
  assign div_start = is_div_op(op) && reset_n;

  div_unit u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .signed_op (op == ALU_DIV || op == ALU_REM),
    .rem_op    (op == ALU_REM || op == ALU_REMU),
    .a         (op_a),
    .b         (op_b),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  assign ex_busy = div_busy;

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_OR:     alu_res = op_a | op_b;
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_SLL:    alu_res = op_a << op_b[4:0];
      ALU_SRL:    alu_res = op_a >> op_b[4:0];
      ALU_SRA:    alu_res = 32'($signed(op_a) >>> op_b[4:0]);
      ALU_SLT:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   alu_res = {31'b0, op_a < op_b};
      ALU_MUL:    alu_res = product[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  alu_res = product[63:32];
      ALU_DIV,
      ALU_DIVU,
      ALU_REM,
      ALU_REMU:   alu_res = div_done ? div_result : '0;
      default:    alu_res = '0;
    endcase
  end

  always_comb begin
    ex_mem_d = '0;
    if (!ex_busy) begin
      ex_mem_d.reg_write  = ID_EX_reg_write;
      ex_mem_d.mem_to_reg = ID_EX_mem_to_reg;
      ex_mem_d.mem_read   = ID_EX_mem_read;
      ex_mem_d.mem_write  = ID_EX_mem_write;
      ex_mem_d.alu_out    = alu_res;
      ex_mem_d.data_b     = fwd_b;
      ex_mem_d.rd         = ID_EX_rd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ex_mem_q <= '0;
    else          ex_mem_q <= ex_mem_d;
  end

  assign EX_MEM_reg_write  = ex_mem_q.reg_write;
  assign EX_MEM_mem_to_reg = ex_mem_q.mem_to_reg;
  assign EX_MEM_mem_read   = ex_mem_q.mem_read;
  assign EX_MEM_mem_write  = ex_mem_q.mem_write;
  assign EX_MEM_alu_out    = ex_mem_q.alu_out;
  assign EX_MEM_dataB      = ex_mem_q.data_b;
  assign EX_MEM_rd         = ex_mem_q.rd;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_ex_stage;
  import rv32_pkg::*;

  logic        clk, reset_n;
  logic        ID_EX_reg_write, ID_EX_mem_to_reg, ID_EX_mem_read, ID_EX_mem_write;
  logic [4:0]  ID_EX_alu_op;
  logic        ID_EX_alu_src;
  logic [31:0] ID_EX_dataA, ID_EX_dataB, ID_EX_imm;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic        MEM_WB_reg_write;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] wb_data;
  logic        EX_MEM_reg_write, EX_MEM_mem_to_reg, EX_MEM_mem_read, EX_MEM_mem_write;
  logic [31:0] EX_MEM_alu_out, EX_MEM_dataB;
  logic [4:0]  EX_MEM_rd;
  logic        ex_busy;

  int tests = 0;
  int fails = 0;

  ex_stage dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ID_EX_reg_write   (ID_EX_reg_write),
    .ID_EX_mem_to_reg  (ID_EX_mem_to_reg),
    .ID_EX_mem_read    (ID_EX_mem_read),
    .ID_EX_mem_write   (ID_EX_mem_write),
    .ID_EX_alu_op      (ID_EX_alu_op),
    .ID_EX_alu_src     (ID_EX_alu_src),
    .ID_EX_dataA       (ID_EX_dataA),
    .ID_EX_dataB       (ID_EX_dataB),
    .ID_EX_imm         (ID_EX_imm),
    .ID_EX_rs1         (ID_EX_rs1),
    .ID_EX_rs2         (ID_EX_rs2),
    .ID_EX_rd          (ID_EX_rd),
    .MEM_WB_reg_write  (MEM_WB_reg_write),
    .MEM_WB_rd         (MEM_WB_rd),
    .wb_data           (wb_data),
    .EX_MEM_reg_write  (EX_MEM_reg_write),
    .EX_MEM_mem_to_reg (EX_MEM_mem_to_reg),
    .EX_MEM_mem_read   (EX_MEM_mem_read),
    .EX_MEM_mem_write  (EX_MEM_mem_write),
    .EX_MEM_alu_out    (EX_MEM_alu_out),
    .EX_MEM_dataB      (EX_MEM_dataB),
    .EX_MEM_rd         (EX_MEM_rd),
    .ex_busy           (ex_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model: RISC-V semantics via wide integer arithmetic.
  function automatic logic [31:0] ref_alu(alu_op_e op, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] ua64, ub64, pu;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'b0, b});
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_SLL:    return a << b[4:0];
      ALU_SRL:    return a >> b[4:0];
      ALU_SRA:    return 32'($signed(a) >>> b[4:0]);
      ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      ALU_MUL:    begin p = sa * sb; return p[31:0]; end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
      ALU_MULHU:  begin pu = ua64 * ub64; return pu[63:32]; end
      ALU_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      ALU_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      ALU_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      ALU_REMU:   begin if (b == 0) return a; return a % b; end
      default:    return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic src, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] ctrl);
    ID_EX_alu_op  = op;
    ID_EX_dataA   = a;
    ID_EX_dataB   = b;
    ID_EX_imm     = imm;
    ID_EX_alu_src = src;
    ID_EX_rs1     = rs1;
    ID_EX_rs2     = rs2;
    ID_EX_rd      = rd;
    {ID_EX_reg_write, ID_EX_mem_to_reg, ID_EX_mem_read, ID_EX_mem_write} = ctrl;
  endtask

  function automatic logic [31:0] ctrl_word();
    return {28'b0, EX_MEM_reg_write, EX_MEM_mem_to_reg, EX_MEM_mem_read, EX_MEM_mem_write};
  endfunction

  // Issue a single-cycle op at a negedge; check the EX/MEM register after the next posedge.
  task automatic run_fast(input string tag, input alu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic src,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [3:0] ctrl, input logic [31:0] exp_out,
                          input logic [31:0] exp_b);
    @(negedge clk);
    set_instr(op, a, b, imm, src, rs1, rs2, rd, ctrl);
    #1;
    check({tag, "_busy"}, {31'b0, ex_busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_out"}, EX_MEM_alu_out, exp_out);
    check({tag, "_dataB"}, EX_MEM_dataB, exp_b);
    check({tag, "_ctrl"}, ctrl_word(), {28'b0, ctrl});
    check({tag, "_rd"}, {27'b0, EX_MEM_rd}, {27'b0, rd});
  endtask

  // Issue a divide; count busy cycles, require bubbles meanwhile, then check the result.
  task automatic run_div(input string tag, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    int busy_cycles;
    int bubble_bad;
    busy_cycles = 0;
    bubble_bad  = 0;
    @(negedge clk);
    set_instr(op, a, b, 32'h0, 1'b0, 5'd0, 5'd0, rd, 4'b1000);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!ex_busy) break;
      busy_cycles++;
      @(posedge clk);
      #1;
      if (ctrl_word() != 0 || EX_MEM_alu_out != 0 || EX_MEM_dataB != 0 || EX_MEM_rd != 0)
        bubble_bad++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, busy_cycles, 32'd33);
    check({tag, "_bubbles"}, bubble_bad, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_result"}, EX_MEM_alu_out, ref_alu(op, a, b));
    check({tag, "_ctrl"}, ctrl_word(), 32'h8);
    check({tag, "_rd"}, {27'b0, EX_MEM_rd}, {27'b0, rd});
  endtask

  initial begin
    alu_op_e     rop;
    logic [31:0] ra, rb, rimm, ropb;
    logic        rsrc;
    logic [3:0]  rctrl;
    logic [4:0]  rrd;

    reset_n          = 1'b0;
    MEM_WB_reg_write = 1'b0;
    MEM_WB_rd        = 5'd0;
    wb_data          = 32'h0;
    set_instr(ALU_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 4'b0000);

    // Reset state
    #1;
    check("rst_ctrl", ctrl_word(), 32'h0);
    check("rst_out", EX_MEM_alu_out, 32'h0);
    check("rst_dataB", EX_MEM_dataB, 32'h0);
    check("rst_rd", {27'b0, EX_MEM_rd}, 32'h0);
    check("rst_busy", {31'b0, ex_busy}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Forwarding: EX/MEM beats MEM/WB
    run_fast("fwd_setup", ALU_ADD, 32'h10, 32'h1, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 4'b1000,
             32'h11, 32'h1);
    MEM_WB_reg_write = 1'b1; MEM_WB_rd = 5'd5; wb_data = 32'h22;
    run_fast("fwd_prio", ALU_ADD, 32'hDEAD, 32'h1, 32'h0, 1'b0, 5'd5, 5'd0, 5'd0, 4'b1000,
             32'h12, 32'h1);
    // x0 never forwards even when both rd fields are 0
    MEM_WB_rd = 5'd0;
    run_fast("fwd_x0", ALU_ADD, 32'h33, 32'h1, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 4'b1000,
             32'h34, 32'h1);
    // MEM/WB only on rs2 (EX_MEM_rd = 9 does not match rs2 = 7)
    MEM_WB_rd = 5'd7; wb_data = 32'h100;
    run_fast("fwd_memwb", ALU_ADD, 32'h1, 32'hBAD, 32'h0, 1'b0, 5'd0, 5'd7, 5'd9, 4'b1000,
             32'h101, 32'h100);
    // Immediate as opB while EX_MEM_dataB still carries forwarded rs2
    MEM_WB_reg_write = 1'b0;
    run_fast("fwd_imm", ALU_ADD, 32'h3, 32'hBAD, 32'h2, 1'b1, 5'd0, 5'd9, 5'd1, 4'b0101,
             32'h5, 32'h101);

    // Directed boundary ops
    run_fast("mulh", ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0, 5'd0, 5'd0, 5'd2,
             4'b1000, 32'h4000_0000, 32'h8000_0000);
    run_fast("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 5'd0, 5'd2,
             4'b1000, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    run_fast("sra", ALU_SRA, 32'h8000_0000, 32'd31, 32'h0, 1'b0, 5'd0, 5'd0, 5'd2,
             4'b1000, 32'hFFFF_FFFF, 32'd31);
    run_fast("sltu", ALU_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 5'd0, 5'd2,
             4'b1000, 32'h1, 32'hFFFF_FFFF);
    run_fast("unknown_op", alu_op_e'(5'd25), 32'h1234, 32'h5678, 32'h0, 1'b0, 5'd0, 5'd0,
             5'd4, 4'b1111, 32'h0, 32'h5678);

    // Divides
    run_div("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6);
    check("div_neg_value", EX_MEM_alu_out, 32'hFFFF_FFFD);
    run_div("rem_neg", ALU_REM, 32'hFFFF_FFF9, 32'd2, 5'd6);
    check("rem_neg_value", EX_MEM_alu_out, 32'hFFFF_FFFF);
    run_div("divu_zero", ALU_DIVU, 32'd5, 32'd0, 5'd7);
    check("divu_zero_value", EX_MEM_alu_out, 32'hFFFF_FFFF);
    run_div("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    check("rem_ovf_value", EX_MEM_alu_out, 32'h0);
    run_div("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    check("div_ovf_value", EX_MEM_alu_out, 32'h8000_0000);
    // Back-to-back, second issued the cycle after DONE
    run_div("divu_b2b_1", ALU_DIVU, 32'd100, 32'd7, 5'd8);
    check("divu_b2b_1_value", EX_MEM_alu_out, 32'd14);
    run_div("divu_b2b_2", ALU_DIVU, 32'd9, 32'd3, 5'd8);
    check("divu_b2b_2_value", EX_MEM_alu_out, 32'd3);

    // Reset mid-RUN with the divide still presented on ID/EX
    @(negedge clk);
    set_instr(ALU_DIV, 32'd1000, 32'd3, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, 4'b1000);
    repeat (10) @(posedge clk);
    #1;
    check("midrun_busy", {31'b0, ex_busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, ex_busy}, 32'h0);
    check("midrst_ctrl", ctrl_word(), 32'h0);
    check("midrst_out", EX_MEM_alu_out, 32'h0);
    check("midrst_dataB", EX_MEM_dataB, 32'h0);
    check("midrst_rd", {27'b0, EX_MEM_rd}, 32'h0);
    @(negedge clk);
    set_instr(ALU_ADD, 32'd3, 32'd4, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, 4'b1000);
    reset_n = 1'b1;
    #1;
    check("postrst_busy", {31'b0, ex_busy}, 32'h0);
    @(posedge clk);
    #1;
    check("postrst_add", EX_MEM_alu_out, 32'd7);

    // Randomized single-cycle ops (no forwarding: rs fields are x0)
    for (int i = 0; i < 60; i++) begin
      rop = alu_op_e'(5'($urandom_range(0, 31)));
      if (is_div_op(rop)) rop = ALU_ADD;
      ra    = $urandom;
      rb    = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rimm  = $urandom;
      rsrc  = 1'($urandom_range(0, 1));
      rctrl = 4'($urandom_range(0, 15));
      rrd   = 5'($urandom_range(0, 31));
      ropb  = rsrc ? rimm : rb;
      run_fast("rand_alu", rop, ra, rb, rimm, rsrc, 5'd0, 5'd0, rrd, rctrl,
               ref_alu(rop, ra, ropb), rb);
    end

    // Randomized divides with occasional special divisors
    for (int i = 0; i < 6; i++) begin
      rop = alu_op_e'(5'($urandom_range(14, 17)));
      ra  = (i == 1) ? 32'h8000_0000 : $urandom;
      case (i % 3)
        0:       rb = 32'($urandom_range(1, 1000));
        1:       rb = (i == 1) ? 32'hFFFF_FFFF : 32'h0;
        default: rb = $urandom;
      endcase
      rrd = 5'($urandom_range(1, 31));
      run_div("rand_div", rop, ra, rb, rrd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
